// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer/size/response encodings and slave state codes
package ahb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;
   localparam logic [2:0] SIZE_BYTE     = 3'd0;
   localparam logic [2:0] SIZE_HALF     = 3'd1;
   localparam logic [2:0] SIZE_WORD     = 3'd2;
   localparam logic       RESP_OKAY     = 1'b0;
   localparam logic       RESP_ERROR    = 1'b1;
   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_WAIT       = 2'd1;
   localparam logic [1:0] ST_ERR1       = 2'd2;
   localparam logic [1:0] ST_ERR2       = 2'd3;
endpackage

// File: rtl/ahb_byte_lane_decoder.sv
// ahb_byte_lane_decoder: little-endian byte enables and misalignment flag from HSIZE/HADDR[1:0]
module ahb_byte_lane_decoder
   import ahb_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr,
   output logic [3:0] be,
   output logic       misalign
);
   assign misalign = (size > SIZE_WORD) || (size == SIZE_HALF && addr[0]) ||
                     (size == SIZE_WORD && addr != 2'b00);
   assign be = misalign ? 4'b0000 :
               size == SIZE_WORD ? 4'b1111 :
               size == SIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
               4'b0001 << addr;
endmodule

// File: rtl/ahb_wait_state_slave.sv
// ahb_wait_state_slave: AHB-Lite memory slave with programmable wait states and two-cycle ERROR response
module ahb_wait_state_slave
   import ahb_pkg::*;
#(
   parameter int AddresseWidth = 32,
   parameter int DataWidth     = 32,
   parameter int MemDepth      = 256,
   parameter int WaitStates    = 2
)(
   input  logic                     HCLK,
   input  logic                     HRESET,
   input  logic                     HSEL,
   input  logic [AddresseWidth-1:0] HADDR,
   input  logic [1:0]               HTRANS,
   input  logic                     HWRITE,
   input  logic [2:0]               HSIZE,
   input  logic [DataWidth-1:0]     HWDATA,
   input  logic                     HREADY,
   output logic [DataWidth-1:0]     HRDATA,
   output logic                     HREADYOUT,
   output logic                     HRESP
);
   localparam int IW = $clog2(MemDepth);
   logic [1:0]           state;
   logic [3:0]           cnt;
   logic                 pend;
   logic                 wr_r;
   logic [IW-1:0]        idx_r;
   logic [3:0]           be_r;
   logic [3:0]           be;
   logic                 misalign;
   logic                 accept;
   logic                 bad;
   logic [DataWidth-1:0] mem [MemDepth];

   ahb_byte_lane_decoder u_dec (.size(HSIZE), .addr(HADDR[1:0]), .be(be), .misalign(misalign));

   assign HREADYOUT = state != ST_WAIT && state != ST_ERR1;
   assign HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
   assign HRDATA    = pend && !wr_r ? mem[idx_r] : '0;
   assign accept    = HREADYOUT && HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
   assign bad       = misalign || |HADDR[AddresseWidth-1:IW+2];

   // pend marks the OKAY completion cycle of the registered transfer
   always_ff @(posedge HCLK)
      if (HRESET) begin
         state <= ST_IDLE;
         cnt   <= '0;
         pend  <= 1'b0;
         wr_r  <= 1'b0;
         idx_r <= '0;
         be_r  <= '0;
      end else if (!HREADYOUT) begin
         state <= state == ST_ERR1 ? ST_ERR2 : cnt == 4'd1 ? ST_IDLE : ST_WAIT;
         pend  <= state == ST_WAIT && cnt == 4'd1;
         cnt   <= state == ST_WAIT ? cnt - 4'd1 : cnt;
      end else begin
         state <= !accept ? ST_IDLE : bad ? ST_ERR1 : WaitStates == 0 ? ST_IDLE : ST_WAIT;
         pend  <= accept && !bad && WaitStates == 0;
         cnt   <= accept && !bad ? 4'(WaitStates) : 4'd0;
         if (accept) begin
            idx_r <= HADDR[IW+1:2];
            be_r  <= be;
            wr_r  <= HWRITE;
         end
      end

   always_ff @(posedge HCLK)
      if (!HRESET && pend && wr_r)
         for (int b = 0; b < 4; b++)
            if (be_r[b]) mem[idx_r][8*b +: 8] <= HWDATA[8*b +: 8];
endmodule

// File: tb/tb_ahb_wait_state_slave.sv
// tb_ahb_wait_state_slave: transaction-level model driving per-cycle vectors into WaitStates=2 and =0 instances
module tb_ahb_wait_state_slave;
   import ahb_pkg::*;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xfer_t;

   typedef struct {
      xfer_t       a;
      logic [31:0] hwdata;
      logic        ro;
      logic        rs;
      logic [31:0] rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, sel, write, ready, act0;
   logic [1:0]  trans;
   logic [2:0]  size;
   logic [31:0] addr, hwdata;
   logic [31:0] rd2, rd0;
   logic        ro2, ro0, rs2, rs0;
   logic [31:0] mm [2][256];
   xfer_t       prev, idle;
   vec_t        vq[$];
   int          pass_n = 0;
   int          tot_n  = 0;

   always #5 clk = ~clk;

   ahb_wait_state_slave #(.WaitStates(2)) d2 (
      .HCLK(clk), .HRESET(rst), .HSEL(sel && !act0), .HADDR(addr), .HTRANS(trans),
      .HWRITE(write), .HSIZE(size), .HWDATA(hwdata), .HREADY(ready),
      .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(rs2));

   ahb_wait_state_slave #(.WaitStates(0)) d0 (
      .HCLK(clk), .HRESET(rst), .HSEL(sel && act0), .HADDR(addr), .HTRANS(trans),
      .HWRITE(write), .HSIZE(size), .HWDATA(hwdata), .HREADY(ready),
      .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));

   function automatic xfer_t mk(logic s, logic [1:0] t, logic [31:0] a, logic w, logic [2:0] z, logic [31:0] d);
      xfer_t x;
      x.sel = s; x.trans = t; x.addr = a; x.write = w; x.size = z; x.wdata = d;
      return x;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s (ws=%0d t=%0t): got %h expected %h", nm, act0 ? 0 : 2, $time, act, exp);
   endtask

   task automatic check_out(input string tag, input logic ro, input logic rs, input logic [31:0] rd);
      check({tag, " hreadyout"}, 32'(act0 ? ro0 : ro2), 32'(ro));
      check({tag, " hresp"}, 32'(act0 ? rs0 : rs2), 32'(rs));
      check({tag, " hrdata"}, act0 ? rd0 : rd2, rd);
   endtask

   // Expand the data phase of prev into per-cycle vectors while t sits in the address phase
   task automatic add(input xfer_t t);
      int    k, w, n, idx, lane;
      logic  live, err;
      vec_t  v;
      k    = act0 ? 1 : 0;
      w    = act0 ? 0 : 2;
      live = prev.sel && prev.trans[1];
      n    = 1 << prev.size;
      err  = live && (prev.size > 2 || int'(prev.addr) % n != 0 || prev.addr / 4 >= 256);
      v.a = t; v.hwdata = prev.wdata; v.rd = '0; v.rs = 1'b0; v.ro = 1'b1;
      if (!live) vq.push_back(v);
      else if (err) begin
         v.rs = 1'b1; v.ro = 1'b0; vq.push_back(v);
         v.ro = 1'b1; vq.push_back(v);
      end else begin
         idx = int'(prev.addr / 4);
         v.ro = 1'b0;
         repeat (w) vq.push_back(v);
         v.ro = 1'b1;
         if (prev.write)
            for (int i = 0; i < n; i++) begin
               lane = int'(prev.addr % 4) + i;
               mm[k][idx][8*lane +: 8] = prev.wdata[8*lane +: 8];
            end
         else v.rd = mm[k][idx];
         vq.push_back(v);
      end
      prev = t;
   endtask

   task automatic apply(input string tag);
      vec_t v;
      add(idle);
      while (vq.size() > 0) begin
         v = vq.pop_front();
         sel = v.a.sel; trans = v.a.trans; addr = v.a.addr; write = v.a.write;
         size = v.a.size; hwdata = v.hwdata; ready = v.ro;
         @(negedge clk);
         check_out(tag, v.ro, v.rs, v.rd);
         @(posedge clk); #1;
      end
   endtask

   xfer_t plan2[] = '{
      mk(1, HTRANS_NONSEQ, 32'h10,  1, SIZE_WORD, 32'hDEADBEEF),
      mk(1, HTRANS_NONSEQ, 32'h10,  0, SIZE_WORD, 32'h0),
      mk(1, HTRANS_NONSEQ, 32'h10,  1, SIZE_WORD, 32'h11223344),
      mk(1, HTRANS_SEQ,    32'h11,  1, SIZE_BYTE, 32'h0000AA00),
      mk(1, HTRANS_NONSEQ, 32'h10,  0, SIZE_WORD, 32'h0),
      mk(1, HTRANS_NONSEQ, 32'h2,   0, SIZE_WORD, 32'h0),
      mk(1, HTRANS_NONSEQ, 32'h400, 0, SIZE_WORD, 32'h0),
      mk(1, HTRANS_NONSEQ, 32'h12,  1, SIZE_WORD, 32'hFFFFFFFF),
      mk(1, HTRANS_NONSEQ, 32'h13,  1, SIZE_HALF, 32'hFFFFFFFF),
      mk(1, HTRANS_NONSEQ, 32'h10,  1, 3'd3,      32'hFFFFFFFF),
      mk(1, HTRANS_NONSEQ, 32'h10,  0, SIZE_WORD, 32'h0),
      mk(1, HTRANS_NONSEQ, 32'h12,  1, SIZE_HALF, 32'hBEEF0000),
      mk(0, HTRANS_NONSEQ, 32'h10,  1, SIZE_WORD, 32'h0),
      mk(1, HTRANS_BUSY,   32'h10,  1, SIZE_WORD, 32'h0),
      mk(1, HTRANS_NONSEQ, 32'h10,  0, SIZE_WORD, 32'h0),
      mk(1, HTRANS_NONSEQ, 32'h20,  1, SIZE_WORD, 32'h0)
   };

   xfer_t plan0[] = '{
      mk(1, HTRANS_NONSEQ, 32'h0,   1, SIZE_WORD, 32'h5),
      mk(1, HTRANS_NONSEQ, 32'h0,   0, SIZE_WORD, 32'h0),
      mk(1, HTRANS_NONSEQ, 32'h3,   1, SIZE_BYTE, 32'h77000000),
      mk(1, HTRANS_NONSEQ, 32'h0,   0, SIZE_WORD, 32'h0),
      mk(1, HTRANS_NONSEQ, 32'h1,   0, SIZE_HALF, 32'h0),
      mk(1, HTRANS_NONSEQ, 32'h0,   0, SIZE_WORD, 32'h0)
   };

   task automatic random_run(input int n);
      xfer_t x;
      for (int i = 0; i < 16; i++) add(mk(1, HTRANS_NONSEQ, 32'(4*i), 1, SIZE_WORD, $urandom));
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 7) == 0)
            x = mk(1'($urandom), 2'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), 1'($urandom), SIZE_WORD, $urandom);
         else
            x = mk(1, $urandom_range(0, 1) ? HTRANS_SEQ : HTRANS_NONSEQ,
                   $urandom_range(0, 9) == 0 ? 32'h400 + 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 63)),
                   1'($urandom), 3'($urandom_range(0, 3)), $urandom);
         add(x);
      end
      apply("random");
   endtask

   initial begin
      idle = mk(0, HTRANS_IDLE, 32'h0, 0, SIZE_BYTE, 32'h0);
      prev = idle;
      act0 = 1'b0;
      rst = 1'b1; sel = 1'b0; trans = HTRANS_IDLE; addr = '0; write = 1'b0;
      size = SIZE_WORD; hwdata = '0; ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      check_out("reset ws2", 1'b1, 1'b0, 32'h0);
      act0 = 1'b1;
      check_out("reset ws0", 1'b1, 1'b0, 32'h0);
      act0 = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (plan2[i]) add(plan2[i]);
      apply("directed ws2");

      // Another slave stalls the bus: our request must not be accepted
      sel = 1'b1; trans = HTRANS_NONSEQ; addr = 32'h10; write = 1'b0; size = SIZE_WORD; ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_out("stalled", 1'b1, 1'b0, 32'h0);
         @(posedge clk); #1;
      end
      trans = HTRANS_IDLE; ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_out("after stall", 1'b1, 1'b0, 32'h0);
         @(posedge clk); #1;
      end

      // Reset during the wait states of a write abandons it
      sel = 1'b1; trans = HTRANS_NONSEQ; addr = 32'h20; write = 1'b1; size = SIZE_WORD;
      @(negedge clk);
      check_out("rst-wr addr", 1'b1, 1'b0, 32'h0);
      @(posedge clk); #1;
      trans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF; ready = 1'b0;
      @(negedge clk);
      check_out("rst-wr wait1", 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_out("rst-wr wait2", 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; ready = 1'b1;
      @(negedge clk);
      check_out("rst-wr after", 1'b1, 1'b0, 32'h0);
      @(posedge clk); #1;

      // Reset coinciding with acceptance drops the transfer
      trans = HTRANS_NONSEQ; write = 1'b0; addr = 32'h10; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; trans = HTRANS_IDLE;
      repeat (2) begin
         @(negedge clk);
         check_out("rst-accept", 1'b1, 1'b0, 32'h0);
         @(posedge clk); #1;
      end

      add(mk(1, HTRANS_NONSEQ, 32'h20, 0, SIZE_WORD, 32'h0));
      apply("read after reset");
      random_run(80);

      act0 = 1'b1;
      foreach (plan0[i]) add(plan0[i]);
      apply("directed ws0");
      random_run(80);

      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
